// File: rtl/arm_mc_pkg.sv
// ---------------------------------------------------------------------------
// arm_mc_pkg
// Shared definitions for the multicycle ARM controller:
//   - state_t    : main FSM state encoding (4-bit, FETCH = 0)
//   - OP_*       : instruction class encodings taken from Op[27:26]
//   - ALU_*      : ALUControl codes driven to the datapath ALU
//   - CMD_*      : data-processing cmd field values (Funct[4:1])
//   - RES_*      : ResultSrc mux encodings
//   - SRCB_*     : ALUSrcB mux encodings
//   - COND_*     : ARM condition field codes
//   - aluDecode  : cmd -> ALUControl mapping for the execute states
// ---------------------------------------------------------------------------
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Unsupported data-processing commands fall back to ADD so the ALU
  // always has a defined operation.
  function automatic logic [1:0] aluDecode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: aluDecode = ALU_ADD;
      CMD_SUB: aluDecode = ALU_SUB;
      CMD_AND: aluDecode = ALU_AND;
      CMD_ORR: aluDecode = ALU_ORR;
      default: aluDecode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/arm_multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// arm_multicycle_controller_if
// Bundle between the multicycle controller and its datapath.
//   Instr[19:0]   : IR bits [31:12] (Cond, Op, Funct, Rn, Rd)
//   ALUFlags[3:0] : NZCV from the datapath ALU, current cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite : enables / selects
//   ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc : 2-bit selects
//   ALUSrcA       : 0 = RD1, 1 = PC
//   State, Flags  : observability of FSM state and stored NZCV
// Modports: master = controller, slave = datapath side.
// ---------------------------------------------------------------------------
interface arm_multicycle_controller_if;

  logic [19:0]              Instr;
  logic [3:0]               ALUFlags;
  logic                     PCWrite;
  logic                     AdrSrc;
  logic                     MemWrite;
  logic                     IRWrite;
  logic [1:0]               ResultSrc;
  logic [1:0]               ALUControl;
  logic                     ALUSrcA;
  logic [1:0]               ALUSrcB;
  logic [1:0]               ImmSrc;
  logic                     RegWrite;
  logic [1:0]               RegSrc;
  arm_mc_pkg::state_t       State;
  logic [3:0]               Flags;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc, State, Flags
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc, State, Flags
  );

endinterface

// File: rtl/arm_mc_condcheck.sv
// ---------------------------------------------------------------------------
// arm_mc_condcheck
// Holds the NZCV flag register and evaluates the ARM condition field.
//   clk, reset         : clock, async active-low reset (clears flags)
//   i_cond[3:0]        : Cond field of the current instruction
//   i_aluFlags[3:0]    : NZCV produced by the ALU this cycle
//   i_flagWrite[1:0]   : requested update, [1] = N,Z  [0] = C,V
//   o_condEx           : condition passes against the stored flags
//   o_flags[3:0]       : stored NZCV
// ---------------------------------------------------------------------------
module arm_mc_condcheck
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_aluFlags,
  input  logic [1:0] i_flagWrite,
  output logic       o_condEx,
  output logic [3:0] o_flags
);

  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v;
  logic       w_condEx;
  logic [1:0] w_flagWrite;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Condition uses the stored (pre-update) flags, so an instruction's own
  // flag write can never change whether that same instruction executes.
  always_comb begin
    w_condEx = 1'b0;
    case (i_cond)
      COND_EQ: w_condEx = w_z;
      COND_NE: w_condEx = ~w_z;
      COND_CS: w_condEx = w_c;
      COND_CC: w_condEx = ~w_c;
      COND_MI: w_condEx = w_n;
      COND_PL: w_condEx = ~w_n;
      COND_VS: w_condEx = w_v;
      COND_VC: w_condEx = ~w_v;
      COND_HI: w_condEx = w_c & ~w_z;
      COND_LS: w_condEx = ~w_c | w_z;
      COND_GE: w_condEx = (w_n == w_v);
      COND_LT: w_condEx = (w_n != w_v);
      COND_GT: w_condEx = ~w_z & (w_n == w_v);
      COND_LE: w_condEx = w_z | (w_n != w_v);
      COND_AL: w_condEx = 1'b1;
      default: w_condEx = 1'b0;
    endcase
  end

  assign w_flagWrite = i_flagWrite & {2{w_condEx}};

  // N,Z and C,V have separate enables: logical ops keep the old carry/overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (w_flagWrite[1]) r_flags[3:2] <= i_aluFlags[3:2];
      if (w_flagWrite[0]) r_flags[1:0] <= i_aluFlags[1:0];
    end
  end

  assign o_condEx = w_condEx;
  assign o_flags  = r_flags;

endmodule

// File: rtl/arm_multicycle_controller.sv
// ---------------------------------------------------------------------------
// arm_multicycle_controller
// Control unit for the multicycle ARM datapath: main FSM (fetch, decode,
// execute, memory, writeback), ALU-op decode and conditional gating of all
// architectural writes.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset (FSM -> RESET_STATE, flags -> 0)
//   bus    : arm_multicycle_controller_if.master (Instr/ALUFlags in,
//            enables and mux selects out, plus State/Flags visibility)
// ---------------------------------------------------------------------------
module arm_multicycle_controller
  import arm_mc_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic                         clk,
  input  logic                         reset,
  arm_multicycle_controller_if.master  bus
);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_cmd;
  logic       w_isExec;
  logic [1:0] w_flagWrite;
  logic       w_condEx;
  logic [3:0] w_flags;
  logic       w_unusedRegFields;

  assign w_cond  = bus.Instr[19:16];
  assign w_op    = bus.Instr[15:14];
  assign w_funct = bus.Instr[13:8];
  assign w_cmd   = w_funct[4:1];
  // Rn/Rd are routed to the register file by the datapath directly.
  assign w_unusedRegFields = ^bus.Instr[7:0];

  // Flag update happens on the edge that ends an execute state; S bit
  // requests it, and only arithmetic commands touch C and V.
  assign w_isExec       = (r_state == EXECUTER) || (r_state == EXECUTEI);
  assign w_flagWrite[1] = w_isExec & w_funct[0];
  assign w_flagWrite[0] = w_flagWrite[1] & ((w_cmd == CMD_ADD) || (w_cmd == CMD_SUB));

  arm_mc_condcheck u_condcheck (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (w_cond),
    .i_aluFlags  (bus.ALUFlags),
    .i_flagWrite (w_flagWrite),
    .o_condEx    (w_condEx),
    .o_flags     (w_flags)
  );

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RESET_STATE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; undefined Op (11) drops straight back to FETCH.
  always_comb begin
    w_nextState = FETCH;
    case (r_state)
      FETCH: w_nextState = DECODE;
      DECODE: begin
        case (w_op)
          OP_MEM:  w_nextState = MEMADR;
          OP_DP:   w_nextState = w_funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   w_nextState = BRANCH;
          default: w_nextState = FETCH;
        endcase
      end
      MEMADR:   w_nextState = w_funct[0] ? MEMRD : MEMWR;
      MEMRD:    w_nextState = MEMWB;
      EXECUTER: w_nextState = ALUWB;
      EXECUTEI: w_nextState = ALUWB;
      default:  w_nextState = FETCH;
    endcase
  end

  // Output logic. FETCH and DECODE both compute PC+4 on the ALU; in DECODE
  // that value is the PC+8 presented to the register file as R15.
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUControl = ALU_ADD;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_RD2;
    bus.RegWrite   = 1'b0;
    case (r_state)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.PCWrite   = 1'b1;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = w_funct[3] ? ALU_ADD : ALU_SUB;
      end
      MEMRD: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = RES_ALUOUT;
      end
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = w_condEx;
      end
      MEMWR: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = w_condEx;
      end
      EXECUTER: begin
        bus.ALUSrcB    = SRCB_RD2;
        bus.ALUControl = aluDecode(w_cmd);
      end
      EXECUTEI: begin
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = aluDecode(w_cmd);
      end
      ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        bus.RegWrite  = w_condEx;
      end
      BRANCH: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALURESULT;
        bus.PCWrite   = w_condEx;
      end
      default: ;
    endcase
  end

  assign bus.ImmSrc = w_op;
  assign bus.RegSrc = {(w_op == OP_MEM), (w_op == OP_BR)};
  assign bus.State  = r_state;
  assign bus.Flags  = w_flags;

endmodule

// File: doc/arm_multicycle_controller.md
Name: arm_multicycle_controller

Overview:
- Control unit for the multicycle variant of the ARM datapath, where one ALU and one memory port are shared across the cycles of each instruction.
- Main FSM sequences fetch, decode, execute, memory and writeback.
- Also contains the ALU-op decode, the registered NZCV flags and condition gating.
- Sits beside the multicycle datapath and drives all of its enables and mux selects.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Instr  input  20  instruction register bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  input  4  NZCV from datapath ALU, valid in the current cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUResult register
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register enable
- ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ALUSrcA  output  1  0=RD1 register, 1=PC
- ALUSrcB  output  2  00=WD/RD2, 01=ExtImm, 10=constant 4
- ImmSrc  output  2  passes Op directly
- RegWrite  output  1  register file write enable
- RegSrc  output  2  [0]=(Op==10), [1]=(Op==01)

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, Flags=4'b0000.
  - All registered internals are cleared.
  - Outputs take their FETCH values combinationally.
  - Reset deasserting mid-instruction restarts at FETCH; no partial writes are replayed.
- Condition gating:
  - CondEx is computed combinationally from Cond and the stored Flags using the standard ARM table (EQ..AL).
  - Cond=1111 gives CondEx=0.
- States and transitions (one per clock):
  - FETCH -> DECODE.
  - DECODE:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=0 -> EXECUTER.
    - Op=00 with Funct[5]=1 -> EXECUTEI.
    - Op=10 -> BRANCH.
    - Op=11 (undefined) -> FETCH.
  - MEMADR: Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER or EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Outputs not listed for a state are 0 (ALUControl defaults to ADD).
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1 (unconditional PC+4).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 read for R15).
  - MEMADR: ALUSrcA=0, ALUSrcB=01; ALU add, or subtract when Funct[3](U)=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - MEMWR: AdrSrc=1, MemWrite=CondEx.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUControl from Funct[4:1].
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUControl from Funct[4:1].
  - ALUWB: ResultSrc=00, RegWrite=CondEx.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx.
- ALU decode (execute states only):
  - cmd 0100 -> 00; 0010 -> 01; 0000 -> 10; 1100 -> 11.
  - Any other cmd -> 00 (ADD).
- Flag update:
  - Occurs on the clock edge ending EXECUTER or EXECUTEI.
  - Requires S=Funct[0]=1 and CondEx=1.
  - N,Z always load from ALUFlags[3:2].
  - C,V load from ALUFlags[1:0] only for ADD or SUB commands.
- CondEx is sampled with pre-update flags: the flag write and the condition test of the same instruction never interact.
- Latency: branch 3 cycles, STR 4, data-processing 4, LDR 5, undefined 2.

Decomposition:
- Shared package arm_mc_pkg holds:
  - state enum (FETCH..BRANCH, 4-bit);
  - Op encodings (DP=00, MEM=01, BR=10);
  - ALUControl codes;
  - ResultSrc and ALUSrcB encodings;
  - Cond codes.
- Sub-module arm_mc_condcheck: Cond plus Flags -> CondEx; also holds the flag register and its write enables.
- FSM and ALU decode stay in the top module.

Test Plan:
- Reset held low mid-LDR (in MEMRD), then released -> next cycle state=FETCH, Flags=0000, IRWrite=1, PCWrite=1, RegWrite=0.
- Instr=E0821003 (ADD R1,R2,R3) -> FETCH, DECODE, EXECUTER (ALUControl=00, ALUSrcB=00), ALUWB (RegWrite=1, ResultSrc=00), then FETCH; flags unchanged.
- Instr=E5921004 (LDR) -> 5-cycle sequence ending MEMWB with ResultSrc=01, RegWrite=1; Instr=E5821004 (STR) -> MEMWR with AdrSrc=1, MemWrite=1, RegWrite never asserted.
- SUBS Instr=E0521003 with ALUFlags=0110 in EXECUTER -> Flags=0110.
  - Then BEQ 0A000001 -> BRANCH with PCWrite=1.
  - Then BNE 1A000001 -> BRANCH with PCWrite=0.
- ANDS (E0121003) with Flags=0011 and ALUFlags=1000 -> Flags=1011 (C,V preserved); ADDNE (1082 1003 form) with Z=1 -> ALUWB RegWrite=0.
- Instr Op=11 (EC000000) -> DECODE returns to FETCH; no RegWrite, MemWrite or second PCWrite is asserted.
